// File: rtl/mod_pkg.sv
// Shared definitions for mod_dds_engine: mode encodings, PN generator taps, midscale helper.
package mod_pkg;

   localparam logic [1:0] MODE_ASK   = 2'b00;
   localparam logic [1:0] MODE_FSK   = 2'b01;
   localparam logic [1:0] MODE_BPSK  = 2'b10;
   localparam logic [1:0] MODE_DBPSK = 2'b11;

   localparam int PN_MAX = 15;

   // Fibonacci feedback mask over the register; bit n stands for the x^(n+1) term.
   function automatic logic [PN_MAX-1:0] lfsr_taps(input int pn_len);
      case (pn_len)
         9:       return 15'h0110;
         15:      return 15'h6000;
         default: return 15'h0060;
      endcase
   endfunction

   function automatic int midscale(input int data_w);
      return 1 << (data_w - 1);
   endfunction

endpackage

// File: rtl/sine_lut.sv
// Registered sine lookup; the table is computed at elaboration from a first-quadrant magnitude.
// Build option MOD_QUARTER_LUT_EN keeps only the first quadrant and rebuilds the rest by symmetry.
module sine_lut
   import mod_pkg::*;
#(
   parameter int LUT_AW = 8,
   parameter int DATA_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [LUT_AW-1:0] addr,
   output logic [DATA_W-1:0] data
);

   localparam int N = 1 << LUT_AW;
   localparam int Q = N / 4;
   localparam int M = midscale(DATA_W);
   localparam logic [DATA_W-1:0] MID = DATA_W'(M);

   // round((M-1)*sin(pi/2 * k/Q)) for k in 0..Q, via a Taylor series on [0, pi/2]
   function automatic int quarter_mag(input int k);
      real x;
      real term;
      real sum;
      x = 1.5707963267948966 * real'(k) / real'(Q);
      term = x;
      sum = x;
      for (int n = 1; n < 12; n++) begin
         term = -term * x * x / real'((2 * n) * (2 * n + 1));
         sum = sum + term;
      end
      return $rtoi(real'(M - 1) * sum + 0.5);
   endfunction

`ifdef MOD_QUARTER_LUT_EN
   localparam logic [LUT_AW-2:0] QV = (LUT_AW-1)'(Q);

   logic [DATA_W-1:0] rom [Q+1];
   logic [LUT_AW-3:0] low;
   logic [LUT_AW-2:0] qidx;
   logic [DATA_W-1:0] qval;

   for (genvar g = 0; g <= Q; g++) begin : g_rom
      assign rom[g] = DATA_W'(M + quarter_mag(g));
   end

   // Odd quadrants mirror the address; the lower half reflects about M (2M - v == -v mod 2^DATA_W).
   always_comb begin
      low  = addr[LUT_AW-3:0];
      qidx = addr[LUT_AW-2] ? (QV - {1'b0, low}) : {1'b0, low};
      qval = rom[qidx];
   end

   always_ff @(posedge clk) begin
      if (reset) data <= MID;
      else       data <= addr[LUT_AW-1] ? (-qval) : qval;
   end
`else
   function automatic int full_entry(input int k);
      int quad;
      int low_k;
      int mag;
      quad  = k / Q;
      low_k = k % Q;
      mag   = quarter_mag((quad == 1 || quad == 3) ? (Q - low_k) : low_k);
      return (quad >= 2) ? (M - mag) : (M + mag);
   endfunction

   logic [DATA_W-1:0] rom [N];

   for (genvar g = 0; g < N; g++) begin : g_rom
      assign rom[g] = DATA_W'(full_entry(g));
   end

   always_ff @(posedge clk) begin
      if (reset) data <= MID;
      else       data <= rom[addr];
   end
`endif

endmodule

// File: rtl/mod_dds_engine.sv
// Pipelined DDS modulator: PN symbols, two carriers and an ASK/FSK/BPSK/DBPSK sample stream.
// MOD_QUARTER_LUT_EN (inside sine_lut) swaps the full sine table for a quarter-wave one.
module mod_dds_engine
   import mod_pkg::*;
#(
   parameter int ACC_W   = 32,
   parameter int LUT_AW  = 8,
   parameter int DATA_W  = 10,
   parameter int PN_LEN  = 7,
   parameter int SYM_DIV = 100000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        mode_sel,
   input  logic              mode_load,
   input  logic [ACC_W-1:0]  fcw0,
   input  logic [ACC_W-1:0]  fcw1,
   input  logic              sample_ready,
   output logic              sample_valid,
   output logic [DATA_W-1:0] sample_data,
   output logic              pn_bit,
   output logic              diff_bit,
   output logic              sym_strobe,
   output logic [1:0]        mode_active
);

   localparam int CNT_W = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SYM_DIV - 1);
   localparam logic [PN_MAX-1:0] TAPS_ALL = lfsr_taps(PN_LEN);
   localparam logic [PN_LEN-1:0] TAPS     = TAPS_ALL[PN_LEN-1:0];
   localparam logic [DATA_W-1:0] MID      = DATA_W'(midscale(DATA_W));
   localparam logic [LUT_AW-1:0] HALF     = LUT_AW'(1) << (LUT_AW - 1);

   logic [ACC_W-1:0]  acc0, acc1;
   logic [CNT_W-1:0]  cnt;
   logic [PN_LEN-1:0] lfsr;
   logic              fb;
   logic [1:0]        pending;

   logic              b;
   logic [LUT_AW-1:0] sel_addr;
   logic              sel_mid;
   logic [LUT_AW-1:0] addr_r;
   logic              mid1, mid2, v1, v2;
   logic [DATA_W-1:0] lut_data;

   assign sym_strobe = (cnt == CNT_LAST);
   assign fb         = ^(lfsr & TAPS);
   assign pn_bit     = lfsr[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         acc0        <= '0;
         acc1        <= '0;
         cnt         <= '0;
         lfsr        <= '1;
         diff_bit    <= 1'b0;
         pending     <= MODE_ASK;
         mode_active <= MODE_ASK;
      end else begin
         acc0 <= acc0 + fcw0;
         acc1 <= acc1 + fcw1;
         cnt  <= sym_strobe ? '0 : cnt + CNT_W'(1);
         if (mode_load) pending <= mode_sel;
         // A load in the strobe cycle bypasses the pending register so it lands on this boundary.
         if (sym_strobe) begin
            lfsr        <= {lfsr[PN_LEN-2:0], fb};
            diff_bit    <= diff_bit ^ fb;
            mode_active <= mode_load ? mode_sel : pending;
         end
      end
   end

   // Stage 1 input: pick carrier/phase from the current symbol and mode.
   always_comb begin
      b        = (mode_active == MODE_DBPSK) ? diff_bit : pn_bit;
      sel_addr = acc0[ACC_W-1 -: LUT_AW];
      sel_mid  = 1'b0;
      case (mode_active)
         MODE_ASK: sel_mid = !b;
         MODE_FSK: if (b) sel_addr = acc1[ACC_W-1 -: LUT_AW];
         default:  if (!b) sel_addr = acc0[ACC_W-1 -: LUT_AW] ^ HALF;
      endcase
   end

   sine_lut #(
      .LUT_AW (LUT_AW),
      .DATA_W (DATA_W)
   ) u_lut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr_r),
      .data  (lut_data)
   );

   // Handshake: a sample transfers in any cycle with sample_valid && sample_ready. The output
   // register refills with the newest sample whenever it is empty or being taken; while stalled
   // it holds, and the still-running pipeline's samples are dropped (latest-sample decimation).
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_r       <= '0;
         mid1         <= 1'b0;
         mid2         <= 1'b0;
         v1           <= 1'b0;
         v2           <= 1'b0;
         sample_valid <= 1'b0;
         sample_data  <= MID;
      end else begin
         addr_r <= sel_addr;
         mid1   <= sel_mid;
         v1     <= 1'b1;
         mid2   <= mid1;
         v2     <= v1;
         if (v2 && (!sample_valid || sample_ready)) begin
            sample_valid <= 1'b1;
            sample_data  <= mid2 ? MID : lut_data;
         end
      end
   end

endmodule

// File: doc/mod_dds_engine.md
Name: mod_dds_engine

Overview:
Parametrised successor of the fixed ASK/FSK/PSK/DPSK modulator set. Generates the PN symbol stream, two DDS carriers and the selected modulated sample in one pipelined engine, with runtime mode and frequency control. Sits between the key/mode logic and the DAC serializer. Delivers samples over a valid/ready handshake.

Parameters:
ACC_W, 32, phase accumulator width
LUT_AW, 8, sine LUT address width (phase bits used)
DATA_W, 10, output sample width, unsigned offset binary
PN_LEN, 7, LFSR length; supported 7, 9, 15
SYM_DIV, 100000, clocks per symbol (500 Hz at 50 MHz)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mode_sel  in  2  requested mode: 00 ASK, 01 FSK, 10 BPSK, 11 DBPSK
mode_load  in  1  one-cycle pulse; latches mode_sel as pending mode
fcw0  in  ACC_W  carrier 0 frequency control word
fcw1  in  ACC_W  carrier 1 frequency control word (FSK mark)
sample_ready  in  1  DAC serializer accepts sample
sample_valid  out  1  sample_data holds a valid sample
sample_data  out  DATA_W  modulated sample
pn_bit  out  1  current PN symbol
diff_bit  out  1  current differential symbol
sym_strobe  out  1  one-cycle pulse at each symbol boundary
mode_active  out  2  mode currently applied

Behaviour:
- Reset (synchronous, active-high): sample_valid=0, sample_data=2^(DATA_W-1), pn_bit=1, diff_bit=0, sym_strobe=0, mode_active=00. Accumulators, symbol counter and pipeline cleared. LFSR seeded all-ones. Pending mode=00.
- Reset mid-operation: pipeline flushed. sample_valid is low in the cycle after reset is sampled.
- Accumulators: acc0+=fcw0, acc1+=fcw1 every clock, wrapping modulo 2^ACC_W. fcw changes take effect the next clock and are not symbol-aligned. fcw=0 holds the phase.
- Symbol counter: counts 0..SYM_DIV-1 then wraps. sym_strobe=1 in the wrap cycle.
- On the strobe:
  - The Fibonacci LFSR advances (taps from the package). pn_bit = new LFSR output.
  - diff_bit <= diff_bit XOR new pn_bit.
  - mode_active <= pending mode.
- LFSR never enters the all-zero state. Sequence period is 2^PN_LEN-1 symbols.
- mode_load updates the pending mode. Several loads within one symbol: the last one wins. mode_load in the strobe cycle: that mode is applied at the same strobe.
- Sample selection (b = pn_bit; b = diff_bit in DBPSK):
  - ASK: b=1 gives sin(acc0); b=0 gives midscale 2^(DATA_W-1).
  - FSK: b=1 gives sin(acc1); b=0 gives sin(acc0).
  - BPSK/DBPSK: b=1 gives sin(acc0); b=0 gives sin(acc0) with the LUT address MSB inverted (180 deg).
- Sine LUT: address = top LUT_AW bits of the accumulator. Entry k = round(M + (M-1)*sin(2*pi*k/2^LUT_AW)), with M = 2^(DATA_W-1).
- Pipeline: stage 1 selects the address, stage 2 registers the LUT read, stage 3 is the output register. A symbol or phase change in cycle N appears on sample_data in cycle N+3 when sample_ready is held high.
- Handshake, output register:
  - It loads the newest pipeline sample whenever (!sample_valid || sample_ready).
  - While sample_valid && !sample_ready, sample_data is stable.
  - Newer samples are dropped (latest-sample decimation, no FIFO).
  - sample_valid rises 3 cycles after reset release and stays high.

Optional Feature:
MOD_QUARTER_LUT_EN:
- Defined: the LUT stores a quarter wave (2^(LUT_AW-2)+1 entries) and reconstructs the full wave by address mirroring and value reflection about M. Output is bit-identical to the full table and latency is unchanged.
- Undefined: a full 2^LUT_AW-entry table.

Decomposition:
- Package mod_pkg holds: mode encoding constants (MODE_ASK/FSK/BPSK/DBPSK), the LFSR tap function per PN_LEN (7: x^7+x^6+1, 9: x^9+x^5+1, 15: x^15+x^14+1), and a midscale function of DATA_W.
- One sub-module, sine_lut: registered read, generate-time table, contains the MOD_QUARTER_LUT_EN option.

Test Plan:
All scenarios use DATA_W=10, LUT_AW=8, SYM_DIV=8, PN_LEN=7, fcw0=2^30, fcw1=2^29, sample_ready=1 unless stated.

1. Reset asserted 3 cycles -> sample_valid=0, sample_data=512, pn_bit=1, diff_bit=0, mode_active=00. sample_valid=1 on the 3rd cycle after release.
2. Free run 127*8 clocks -> sym_strobe every 8 clocks. pn_bit matches the x^7+x^6+1 model with period 127. diff_bit toggles exactly on strobes where pn_bit=1.
3. ASK -> while pn_bit=1, sample_data cycles 512,1023,512,1; while pn_bit=0, constant 512.
4. BPSK load -> pn_bit=1 gives 512,1023,512,1; pn_bit=0 gives 512,1,512,1023. FSK pn_bit=1 gives an 8-sample period.
5. Mode timing:
   - mode_load=FSK in symbol cycle 3 -> mode_active unchanged until the next strobe, then 01.
   - Loads BPSK then DBPSK in one symbol -> 11 applied.
   - mode_load in the strobe cycle -> applied at that strobe.
6. Handshake: sample_ready low 5 cycles -> sample_data and sample_valid constant. On ready high, the newest sample appears the next cycle. Repeat with MOD_QUARTER_LUT_EN defined -> identical trace.
